// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one decimal digit per clock, LSD first, with a registered result.
// Optional nine's-complement subtraction is enabled by defining BCD_SUBTRACT_EN.

// state | meaning
// IDLE  | waiting for start; sum/outcarry hold the last completed result
// RUN   | one digit per edge, digit 0 first; the carry is registered between digits
// FIN   | done pulse for one cycle; a start here launches the next operation
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   augend,
    input  logic [4*DIGITS-1:0]   addend,
    input  logic                  cin,
`ifdef BCD_SUBTRACT_EN
    input  logic                  sub,
`endif
    output logic [4*DIGITS-1:0]   sum,
    output logic                  outcarry,
    output logic                  busy,
    output logic                  done,
    output logic                  bad_digit
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            oc_q, oc_d;
    logic            bad_q, bad_d;

    logic [4:0]      z;
    logic [3:0]      dig;
    logic            dig_carry;
    logic            cap_sub;

    function automatic logic [W-1:0] nines(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'd9 - v[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic any_bad(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

`ifdef BCD_SUBTRACT_EN
    assign cap_sub = sub;
`else
    assign cap_sub = 1'b0;
`endif

    // Decimal correction; for out-of-range digits the low nibble of z+6 is still taken.
    always_comb begin
        z         = {1'b0, a_q[idx_q*4 +: 4]} + {1'b0, b_q[idx_q*4 +: 4]} + {4'd0, carry_q};
        dig_carry = (z > 5'd9);
        dig       = dig_carry ? (z[3:0] + 4'd6) : z[3:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        oc_d    = oc_q;
        bad_d   = bad_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d     = augend;
                    b_d     = cap_sub ? nines(addend) : addend;
                    carry_d = cap_sub ? 1'b1 : cin;
                    idx_d   = '0;
                    acc_d   = '0;
                    bad_d   = any_bad(augend) | any_bad(addend);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d[idx_q*4 +: 4] = dig;
                carry_d = dig_carry;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    sum_d   = acc_d;
                    oc_d    = dig_carry;
                    state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            oc_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            oc_q    <= oc_d;
            bad_q   <= bad_d;
        end
    end

    assign sum       = sum_q;
    assign outcarry  = oc_q;
    assign bad_digit = bad_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_FIN);

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 Parameter DIGITS, default 4, is the number of BCD digits per operand; legal range is 1..16.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: request to begin an addition; sampled only while idle.
REQ-005 Port augend, input, 4*DIGITS bits: packed BCD operand A; digit 0 is bits [3:0] (least significant).
REQ-006 Port addend, input, 4*DIGITS bits: packed BCD operand B, packed the same way as augend.
REQ-007 Port cin, input, 1 bit: carry into digit 0.
REQ-008 Port sum, output, 4*DIGITS bits: registered BCD result.
REQ-009 Port outcarry, output, 1 bit: registered decimal carry out of the most significant digit.
REQ-010 Port busy, output, 1 bit: high while an operation is in progress.
REQ-011 Port done, output, 1 bit: one-cycle pulse indicating that sum and outcarry are valid.
REQ-012 Port bad_digit, output, 1 bit: registered flag, high when any captured operand digit was greater than 9.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-014 In IDLE with start=1, the block SHALL on that edge latch augend, addend and cin, clear the digit index to 0, set busy=1 and enter RUN.
REQ-015 In RUN, each edge SHALL process exactly one digit, starting at digit 0 and moving toward the most significant digit.
REQ-016 For each digit, z = a_d + b_d + c is computed 5 bits wide; if z > 9 the digit result is (z+6)[3:0] and the carry is 1, otherwise the digit result is z[3:0] and the carry is 0.
REQ-017 The carry from each digit SHALL feed the next digit on the following cycle.
REQ-018 On the edge that processes digit DIGITS-1, the block SHALL update sum and outcarry together and enter FIN.
REQ-019 The FIN state SHALL last one cycle, with done=1 and busy=0; it SHALL return to IDLE on the next edge.
REQ-020 Latency SHALL be exactly DIGITS+1 cycles from the start-sampling edge to the done-high cycle.
REQ-021 A start accepted while in FIN SHALL begin a new operation; RUN is entered directly on that edge.
REQ-022 start SHALL be ignored during RUN, and inputs changing during RUN SHALL NOT affect the result.
REQ-023 sum and outcarry SHALL hold their last completed values until the next completion; partial results SHALL never be visible on sum.
REQ-024 bad_digit SHALL be computed at operand capture and held until the next capture.
REQ-025 Digits greater than 9 SHALL still be processed by the rule in REQ-016 without halting the operation.
REQ-026 With DIGITS=1, RUN SHALL last exactly one cycle.

Reset
REQ-027 When rst_n=0, the block SHALL immediately and asynchronously enter IDLE and drive sum=0, outcarry=0, busy=0, done=0 and bad_digit=0.
REQ-028 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow, and sum SHALL remain 0.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n is released.

Configuration
REQ-030 When macro BCD_SUBTRACT_EN is defined, the block SHALL add an input port sub (1 bit) that is latched together with the operands.
REQ-031 With BCD_SUBTRACT_EN defined and sub=1, each addend digit SHALL be replaced by its nine's complement (9 - b_d) and the carry into digit 0 SHALL be forced to 1; cin is ignored in this mode.
REQ-032 With BCD_SUBTRACT_EN defined and sub=1, outcarry=1 SHALL mean no borrow occurred, and outcarry=0 SHALL mean a borrow occurred, with sum holding the ten's-complement result.
REQ-033 Without BCD_SUBTRACT_EN, the sub port SHALL be absent and the block SHALL perform addition only.

Verification
REQ-034 With DIGITS=4, augend=9999, addend=0001, cin=0 -> sum=0000 and outcarry=1, with done high exactly 5 cycles after start.
REQ-035 Augend=1234, addend=5678, cin=0 -> sum=6912, outcarry=0, bad_digit=0; augend=0000, addend=0000, cin=1 -> sum=0001.
REQ-036 Start pulsed again 2 cycles into RUN with different operands -> the first result is delivered unchanged and only one done pulse occurs.
REQ-037 rst_n pulled low 2 cycles into RUN -> all outputs go to 0 immediately, no done pulse occurs, and the next start works normally.
REQ-038 Augend digit 0 = 4'hA, addend=0000 -> bad_digit=1 and done still occurs with the REQ-016 result (digit 0 = 0, carry 1 into digit 1).
REQ-039 With BCD_SUBTRACT_EN defined: 0100-0001 -> sum=0099, outcarry=1; 0001-0002 -> sum=9999, outcarry=0.
